// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 machine-mode trap/return controller.
// States, PC source codes, mcause codes and SYSTEM field constants.
package msrv32_pkg;

  localparam logic [1:0] ST_RESET       = 2'b00;
  localparam logic [1:0] ST_OPERATING   = 2'b01;
  localparam logic [1:0] ST_TRAP_TAKEN  = 2'b10;
  localparam logic [1:0] ST_TRAP_RETURN = 2'b11;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_EPC  = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_NEXT = 2'b11;

  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

  localparam logic [3:0] CAUSE_M_SW_IRQ    = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER_IRQ = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT_IRQ   = 4'd11;

  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
  localparam logic [2:0] FUNCT3_PRIV   = 3'b000;
  localparam logic [6:0] FUNCT7_ECALL  = 7'b0000000;
  localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
  localparam logic [4:0] RS2_ECALL     = 5'b00000;
  localparam logic [4:0] RS2_EBREAK    = 5'b00001;
  localparam logic [4:0] RS2_MRET      = 5'b00010;

  typedef struct packed {
    logic       cond;
    logic [3:0] cause;
    logic       i_or_e;
  } trap_info_t;

  function automatic logic is_misaligned_cause(
    input logic [3:0] cause
  );
    return (cause == CAUSE_INSTR_MISALIGNED)
        || (cause == CAUSE_LOAD_MISALIGNED)
        || (cause == CAUSE_STORE_MISALIGNED);
  endfunction

endpackage

// File: rtl/msrv32_machine_control_cause_enc.sv
// Combinational trap priority encoder: exceptions outrank interrupts.
// Interrupt inputs arrive already masked by mstatus.MIE and mie.
module msrv32_trap_cause_enc
  import msrv32_pkg::*;
(
  input  logic       misaligned_instr_in,
  input  logic       illegal_instr_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       e_irq_in,
  input  logic       s_irq_in,
  input  logic       t_irq_in,
  output trap_info_t trap_out
);

  always_comb begin
    trap_out = '0;
    trap_out.cond = misaligned_instr_in | illegal_instr_in
                  | ecall_in | ebreak_in
                  | misaligned_load_in | misaligned_store_in
                  | e_irq_in | s_irq_in | t_irq_in;
    priority case (1'b1)
      misaligned_instr_in:
        trap_out.cause = CAUSE_INSTR_MISALIGNED;
      illegal_instr_in:
        trap_out.cause = CAUSE_ILLEGAL_INSTR;
      ecall_in:
        trap_out.cause = CAUSE_ECALL_M;
      ebreak_in:
        trap_out.cause = CAUSE_BREAKPOINT;
      misaligned_load_in:
        trap_out.cause = CAUSE_LOAD_MISALIGNED;
      misaligned_store_in:
        trap_out.cause = CAUSE_STORE_MISALIGNED;
      e_irq_in: begin
        trap_out.cause  = CAUSE_M_EXT_IRQ;
        trap_out.i_or_e = 1'b1;
      end
      s_irq_in: begin
        trap_out.cause  = CAUSE_M_SW_IRQ;
        trap_out.i_or_e = 1'b1;
      end
      t_irq_in: begin
        trap_out.cause  = CAUSE_M_TIMER_IRQ;
        trap_out.i_or_e = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return controller sitting after msrv32_dec.
// Drives PC select, flush and CSR-update strobes from a 4-state FSM.
module msrv32_machine_control
  import msrv32_pkg::*;
(
  input  logic       ms_riscv32_mp_clk_in,
  input  logic       ms_riscv32_mp_rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       misaligned_instr_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rd_addr_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       e_irq_in,
  input  logic       t_irq_in,
  input  logic       s_irq_in,
  output logic       trap_taken_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       set_cause_out,
  output logic [3:0] cause_out,
  output logic       i_or_e_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out,
  output logic       misaligned_exception_out
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] cause_q;
  logic       i_or_e_q;

  logic       sys_base;
  logic       ecall;
  logic       ebreak;
  logic       mret;
  logic       e_pend;
  logic       s_pend;
  logic       t_pend;
  logic       in_op;
  trap_info_t trap;

  assign sys_base = (opcode_6_to_2_in == OPCODE_SYSTEM)
                 && (funct3_in == FUNCT3_PRIV)
                 && (rs1_addr_in == 5'd0)
                 && (rd_addr_in == 5'd0);

  assign ecall  = sys_base && (funct7_in == FUNCT7_ECALL)
               && (rs2_addr_in == RS2_ECALL);
  assign ebreak = sys_base && (funct7_in == FUNCT7_ECALL)
               && (rs2_addr_in == RS2_EBREAK);
  assign mret   = sys_base && (funct7_in == FUNCT7_MRET)
               && (rs2_addr_in == RS2_MRET);

  assign e_pend = mie_in & meie_in & e_irq_in;
  assign s_pend = mie_in & msie_in & s_irq_in;
  assign t_pend = mie_in & mtie_in & t_irq_in;

  msrv32_trap_cause_enc u_cause_enc (
    .misaligned_instr_in (misaligned_instr_in),
    .illegal_instr_in    (illegal_instr_in),
    .ecall_in            (ecall),
    .ebreak_in           (ebreak),
    .misaligned_load_in  (misaligned_load_in),
    .misaligned_store_in (misaligned_store_in),
    .e_irq_in            (e_pend),
    .s_irq_in            (s_pend),
    .t_irq_in            (t_pend),
    .trap_out            (trap)
  );

  assign in_op = (state == ST_OPERATING);

  always_comb begin
    state_nxt = ST_OPERATING;
    if (in_op) begin
      if (trap.cond)
        state_nxt = ST_TRAP_TAKEN;
      else if (mret)
        state_nxt = ST_TRAP_RETURN;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state    <= ST_RESET;
      cause_q  <= 4'd0;
      i_or_e_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_op && trap.cond) begin
        cause_q  <= trap.cause;
        i_or_e_q <= trap.i_or_e;
      end
    end
  end

  assign trap_taken_out  = in_op & trap.cond;
  assign instret_inc_out = in_op & ~trap.cond;
  assign cause_out       = cause_q;
  assign i_or_e_out      = i_or_e_q;

  assign misaligned_exception_out = (state == ST_TRAP_TAKEN)
                                 & is_misaligned_cause(cause_q)
                                 & ~i_or_e_q;

  always_comb begin
    pc_src_out    = PC_BOOT;
    flush_out     = 1'b0;
    set_cause_out = 1'b0;
    set_epc_out   = 1'b0;
    mie_clear_out = 1'b0;
    mie_set_out   = 1'b0;
    unique case (state)
      ST_RESET: begin
        pc_src_out = PC_BOOT;
        flush_out  = 1'b1;
      end
      ST_OPERATING: begin
        pc_src_out = PC_NEXT;
      end
      ST_TRAP_TAKEN: begin
        pc_src_out    = PC_TRAP;
        flush_out     = 1'b1;
        set_cause_out = 1'b1;
        set_epc_out   = 1'b1;
        mie_clear_out = 1'b1;
      end
      ST_TRAP_RETURN: begin
        pc_src_out  = PC_EPC;
        flush_out   = 1'b1;
        mie_set_out = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed bench for msrv32_machine_control.
// Outputs are packed into one vector and compared to hand-built values.
module tb_msrv32_machine_control;

  logic       clk;
  logic       rst;
  logic       illegal_instr;
  logic       misaligned_load;
  logic       misaligned_store;
  logic       misaligned_instr;
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       mie;
  logic       meie;
  logic       mtie;
  logic       msie;
  logic       e_irq;
  logic       t_irq;
  logic       s_irq;

  logic       trap_taken;
  logic [1:0] pc_src;
  logic       flush;
  logic       set_cause;
  logic [3:0] cause;
  logic       i_or_e;
  logic       set_epc;
  logic       mie_clear;
  logic       mie_set;
  logic       instret_inc;
  logic       misaligned_exc;

  int passed;
  int total;

  logic [14:0] obs;
  logic [14:0] exp_v;

  msrv32_machine_control dut (
    .ms_riscv32_mp_clk_in     (clk),
    .ms_riscv32_mp_rst_in     (rst),
    .illegal_instr_in         (illegal_instr),
    .misaligned_load_in       (misaligned_load),
    .misaligned_store_in      (misaligned_store),
    .misaligned_instr_in      (misaligned_instr),
    .opcode_6_to_2_in         (opcode),
    .funct3_in                (funct3),
    .funct7_in                (funct7),
    .rs1_addr_in              (rs1),
    .rs2_addr_in              (rs2),
    .rd_addr_in               (rd),
    .mie_in                   (mie),
    .meie_in                  (meie),
    .mtie_in                  (mtie),
    .msie_in                  (msie),
    .e_irq_in                 (e_irq),
    .t_irq_in                 (t_irq),
    .s_irq_in                 (s_irq),
    .trap_taken_out           (trap_taken),
    .pc_src_out               (pc_src),
    .flush_out                (flush),
    .set_cause_out            (set_cause),
    .cause_out                (cause),
    .i_or_e_out               (i_or_e),
    .set_epc_out              (set_epc),
    .mie_clear_out            (mie_clear),
    .mie_set_out              (mie_set),
    .instret_inc_out          (instret_inc),
    .misaligned_exception_out (misaligned_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // order: tt pc fl sc cause ie se mc ms ir mx
  assign obs = {trap_taken, pc_src, flush, set_cause, cause, i_or_e,
                set_epc, mie_clear, mie_set, instret_inc,
                misaligned_exc};

  function automatic logic [14:0] mk(
    input logic       tt,
    input logic [1:0] pc,
    input logic       fl,
    input logic       sc,
    input logic [3:0] c,
    input logic       ie,
    input logic       se,
    input logic       mc,
    input logic       ms,
    input logic       ir,
    input logic       mx
  );
    return {tt, pc, fl, sc, c, ie, se, mc, ms, ir, mx};
  endfunction

  task automatic clear_inputs();
    illegal_instr    = 1'b0;
    misaligned_load  = 1'b0;
    misaligned_store = 1'b0;
    misaligned_instr = 1'b0;
    opcode = 5'b01100;
    funct3 = 3'b000;
    funct7 = 7'b0;
    rs1 = 5'd3;
    rs2 = 5'd4;
    rd  = 5'd5;
    mie = 1'b0;
    meie = 1'b0;
    mtie = 1'b0;
    msie = 1'b0;
    e_irq = 1'b0;
    t_irq = 1'b0;
    s_irq = 1'b0;
  endtask

  task automatic set_sys(input logic [6:0] f7, input logic [4:0] r2);
    opcode = 5'b11100;
    funct3 = 3'b000;
    rs1 = 5'd0;
    rd  = 5'd0;
    funct7 = f7;
    rs2 = r2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    #1;
    exp_v = mk(0, 2'b00, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL reset_hold1 got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    rst = 1'b0;
    #1;
    total++;
    if (obs !== exp_v)
      $display("FAIL reset_released got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    #1;
    exp_v = mk(0, 2'b11, 0, 0, 4'd0, 0, 0, 0, 0, 1, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL reset_to_op got=%b want=%b", obs, exp_v);
    else passed++;
  endtask

  task automatic test_illegal();
    illegal_instr = 1'b1;
    #1;
    exp_v = mk(1, 2'b11, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL illegal_op got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    clear_inputs();
    #1;
    exp_v = mk(0, 2'b10, 1, 1, 4'd2, 0, 1, 1, 0, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL illegal_taken got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    #1;
    exp_v = mk(0, 2'b11, 0, 0, 4'd2, 0, 0, 0, 0, 1, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL illegal_back got=%b want=%b", obs, exp_v);
    else passed++;
  endtask

  task automatic test_priority();
    misaligned_store = 1'b1;
    mie = 1'b1;
    meie = 1'b1;
    e_irq = 1'b1;
    #1;
    exp_v = mk(1, 2'b11, 0, 0, 4'd2, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL store_irq_op got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    clear_inputs();
    #1;
    exp_v = mk(0, 2'b10, 1, 1, 4'd6, 0, 1, 1, 0, 0, 1);
    total++;
    if (obs !== exp_v)
      $display("FAIL store_irq_taken got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    misaligned_instr = 1'b1;
    illegal_instr = 1'b1;
    step();
    clear_inputs();
    #1;
    exp_v = mk(0, 2'b10, 1, 1, 4'd0, 0, 1, 1, 0, 0, 1);
    total++;
    if (obs !== exp_v)
      $display("FAIL fetch_misalign got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    mie = 1'b1;
    msie = 1'b1;
    mtie = 1'b1;
    s_irq = 1'b1;
    t_irq = 1'b1;
    step();
    clear_inputs();
    #1;
    exp_v = mk(0, 2'b10, 1, 1, 4'd3, 1, 1, 1, 0, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL sw_over_timer got=%b want=%b", obs, exp_v);
    else passed++;
    step();
  endtask

  task automatic test_mret();
    set_sys(7'b0011000, 5'b00010);
    #1;
    exp_v = mk(0, 2'b11, 0, 0, 4'd3, 1, 0, 0, 0, 1, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL mret_op got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    clear_inputs();
    #1;
    exp_v = mk(0, 2'b01, 1, 0, 4'd3, 1, 0, 0, 1, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL mret_return got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    #1;
    exp_v = mk(0, 2'b11, 0, 0, 4'd3, 1, 0, 0, 0, 1, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL mret_back got=%b want=%b", obs, exp_v);
    else passed++;
  endtask

  task automatic test_mret_irq();
    set_sys(7'b0011000, 5'b00010);
    mie = 1'b1;
    mtie = 1'b1;
    t_irq = 1'b1;
    step();
    clear_inputs();
    #1;
    exp_v = mk(0, 2'b10, 1, 1, 4'd7, 1, 1, 1, 0, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL mret_timer got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    illegal_instr = 1'b0;
    set_sys(7'b0011000, 5'b00010);
    mie = 1'b0;
    mtie = 1'b1;
    t_irq = 1'b1;
    #1;
    exp_v = mk(0, 2'b11, 0, 0, 4'd7, 1, 0, 0, 0, 1, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL mret_masked_op got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    clear_inputs();
    #1;
    exp_v = mk(0, 2'b01, 1, 0, 4'd7, 1, 0, 0, 1, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL mret_masked_ret got=%b want=%b", obs, exp_v);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    set_sys(7'b0000000, 5'b00000);
    step();
    set_sys(7'b0000000, 5'b00001);
    #1;
    exp_v = mk(0, 2'b10, 1, 1, 4'd11, 0, 1, 1, 0, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL ecall_taken got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    #1;
    exp_v = mk(1, 2'b11, 0, 0, 4'd11, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL b2b_op got=%b want=%b", obs, exp_v);
    else passed++;
    step();
    clear_inputs();
    #1;
    exp_v = mk(0, 2'b10, 1, 1, 4'd3, 0, 1, 1, 0, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL ebreak_taken got=%b want=%b", obs, exp_v);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid_trap();
    misaligned_load = 1'b1;
    step();
    clear_inputs();
    #1;
    exp_v = mk(0, 2'b10, 1, 1, 4'd4, 0, 1, 1, 0, 0, 1);
    total++;
    if (obs !== exp_v)
      $display("FAIL load_taken got=%b want=%b", obs, exp_v);
    else passed++;
    rst = 1'b1;
    step();
    #1;
    exp_v = mk(0, 2'b00, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL reset_mid_trap got=%b want=%b", obs, exp_v);
    else passed++;
    rst = 1'b0;
    step();
    #1;
    exp_v = mk(0, 2'b11, 0, 0, 4'd0, 0, 0, 0, 0, 1, 0);
    total++;
    if (obs !== exp_v)
      $display("FAIL reset_recover got=%b want=%b", obs, exp_v);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_illegal();
    test_priority();
    test_mret();
    test_mret_irq();
    test_back_to_back();
    test_reset_mid_trap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/msrv32_machine_control.md
Name: msrv32_machine_control

Overview:
- Machine-mode trap/return controller, directly downstream of msrv32_dec.
- Consumes the decoder's illegal_instr_out, misaligned_load_out and misaligned_store_out, plus SYSTEM-instruction fields and interrupt lines.
- Produces trap_taken_out, which feeds back into msrv32_dec trap_taken_in to suppress register-file and memory writes.
- Also drives PC source select, pipeline flush and the CSR-update strobes: cause, mepc, mstatus.MIE, instret.

Parameters:
- none. All encodings come from msrv32_pkg.

Ports:
- ms_riscv32_mp_clk_in  in  1  system clock, rising edge
- ms_riscv32_mp_rst_in  in  1  synchronous, active-high reset
- illegal_instr_in  in  1  from msrv32_dec
- misaligned_load_in  in  1  from msrv32_dec
- misaligned_store_in  in  1  from msrv32_dec
- misaligned_instr_in  in  1  from the branch/jump target check
- opcode_6_to_2_in  in  5  instr[6:2]
- funct3_in  in  3  instr[14:12]
- funct7_in  in  7  instr[31:25]
- rs1_addr_in  in  5  instr[19:15]
- rs2_addr_in  in  5  instr[24:20]
- rd_addr_in  in  5  instr[11:7]
- mie_in  in  1  mstatus.MIE
- meie_in, mtie_in, msie_in  in  1 each  mie.MEIE / MTIE / MSIE
- e_irq_in, t_irq_in, s_irq_in  in  1 each  external / timer / software interrupt request
- trap_taken_out  out  1  to msrv32_dec trap_taken_in
- pc_src_out  out  2  00 boot, 01 mepc, 10 trap vector, 11 next PC
- flush_out  out  1  kill the instruction in fetch
- set_cause_out  out  1  write mcause
- cause_out  out  4  mcause code
- i_or_e_out  out  1  1 = interrupt, 0 = exception
- set_epc_out  out  1  write mepc
- mie_clear_out  out  1  mstatus MPIE<=MIE, MIE<=0
- mie_set_out  out  1  mstatus MIE<=MPIE
- instret_inc_out  out  1  retire strobe
- misaligned_exception_out  out  1  current trap is a misaligned access or fetch

Behaviour:
- State register, 2 bits: RESET=00, OPERATING=01, TRAP_TAKEN=10, TRAP_RETURN=11.
- Reset:
  - While ms_riscv32_mp_rst_in=1 at a clock edge: state<=RESET, cause register<=0, i_or_e register<=0.
  - Applies from any state, mid-trap included.
- Transitions:
  - RESET -> OPERATING unconditionally.
  - OPERATING -> TRAP_TAKEN if trap_cond.
  - OPERATING -> TRAP_RETURN if mret and not trap_cond.
  - Otherwise OPERATING stays OPERATING.
  - TRAP_TAKEN -> OPERATING and TRAP_RETURN -> OPERATING unconditionally. All inputs are ignored in these flush cycles.
- SYSTEM decode (opcode_6_to_2_in=11100, funct3=000, rs1=0, rd=0):
  - ecall: funct7=0, rs2=00000.
  - ebreak: funct7=0, rs2=00001.
  - mret: funct7=0011000, rs2=00010.
- Interrupt pending: irq = mie_in & ((meie_in&e_irq_in) | (msie_in&s_irq_in) | (mtie_in&t_irq_in)).
- trap_cond = any exception source | ecall | ebreak | irq.
- Cause priority, highest first:
  - misaligned_instr (0), illegal (2), ecall (11), ebreak (3), misaligned_load (4), misaligned_store (6). These give i_or_e=0.
  - Then external (11), software (3), timer (7). These give i_or_e=1.
- Combinational outputs (same cycle):
  - trap_taken_out = (state==OPERATING) & trap_cond.
  - instret_inc_out = (state==OPERATING) & ~trap_cond.
- Moore outputs, decoded from state:
  - RESET: pc_src=00, flush=1.
  - OPERATING: pc_src=11, flush=0.
  - TRAP_TAKEN: pc_src=10, flush=1, set_cause=1, set_epc=1, mie_clear=1.
  - TRAP_RETURN: pc_src=01, flush=1, mie_set=1.
  - All strobes not listed are 0.
- Cause capture:
  - cause_out and i_or_e_out are registered on the OPERATING->TRAP_TAKEN edge and hold until the next trap or reset.
  - misaligned_exception_out = (state==TRAP_TAKEN) & registered cause in {0,4,6} & ~i_or_e.
- Reset output values: pc_src=00, flush=1, cause=0, i_or_e=0, all other outputs 0.
- Loop-freedom: illegal/misaligned inputs must not depend on trap_taken_out. The trap_taken path is combinational, one level deep.
- Back-to-back traps: a second trap is recognised in the first OPERATING cycle after TRAP_TAKEN. There is no lockout.

Decomposition:
- msrv32_pkg holds:
  - state encodings
  - pc_src codes (PC_BOOT, PC_EPC, PC_TRAP, PC_NEXT)
  - mcause exception/interrupt codes
  - SYSTEM opcode, ECALL/EBREAK/MRET field constants
- One sub-module, msrv32_trap_cause_enc: a combinational priority encoder producing trap_cond, cause[3:0] and i_or_e.

Test Plan:
- Reset held 2 cycles, then released -> pc_src 00, flush 1; next cycle OPERATING, pc_src 11, flush 0, instret_inc 1.
- illegal_instr_in=1 in OPERATING -> trap_taken_out=1 and instret_inc=0 the same cycle. Next cycle: pc_src 10, set_cause, set_epc and mie_clear all 1, cause_out=2, i_or_e_out=0.
- misaligned_store_in=1 together with e_irq (mie=1, meie=1) -> cause_out=6, i_or_e=0, misaligned_exception_out=1 in TRAP_TAKEN.
- mret fields (0011000/00010/SYSTEM) with no irq -> TRAP_RETURN: pc_src 01, mie_set 1, flush 1; back to OPERATING after 1 cycle.
- mret with t_irq=1, mie=1, mtie=1 -> TRAP_TAKEN (not TRAP_RETURN), cause_out=7, i_or_e=1; with mie_in=0 -> TRAP_RETURN.
- Reset asserted while in TRAP_TAKEN -> RESET next edge, cause_out=0, pc_src 00.
